// File: rtl/reg_a_writeback_pkg.sv
// Shared definitions for the register-A write-back path: default width, swap FSM
// state encoding and R11/R12 select encodings.
package reg_a_writeback_pkg;

    localparam int WIDTH_DEF = 18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SW_TMP = 2'd1,
        ST_SW_A   = 2'd2,
        ST_SW_B   = 2'd3
    } swap_state_t;

    localparam logic SEL_R11 = 1'b0;
    localparam logic SEL_R12 = 1'b1;

endpackage

// File: rtl/reg_a_swap_fsm.sv
// Sequencer for the three-step R11<->R12 exchange through a temp register.
// state  | meaning
// IDLE   | accepting loads/increments/swap requests
// SW_TMP | tmp <= R11
// SW_A   | R11 <= R12
// SW_B   | R12 <= tmp, done high this cycle
module reg_a_swap_fsm
    import reg_a_writeback_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_idle,
    output logic o_busy,
    output logic o_done,
    output logic o_ld_tmp,
    output logic o_ld_r11,
    output logic o_ld_r12
);

    swap_state_t r_state;
    swap_state_t w_next;
    logic        r_busy;
    logic        r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_SW_B);
        end
    end

    always_comb begin
        w_next   = r_state;
        o_ld_tmp = 1'b0;
        o_ld_r11 = 1'b0;
        o_ld_r12 = 1'b0;
        case (r_state)
            ST_IDLE:   if (i_start) w_next = ST_SW_TMP;
            ST_SW_TMP: begin
                o_ld_tmp = 1'b1;
                w_next   = ST_SW_A;
            end
            ST_SW_A:   begin
                o_ld_r11 = 1'b1;
                w_next   = ST_SW_B;
            end
            ST_SW_B:   begin
                o_ld_r12 = 1'b1;
                w_next   = ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    assign o_idle = (r_state == ST_IDLE);
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/reg_a_writeback.sv
// R11/R12 write-back: bus loads, post-increment with wrap flag, and FSM-driven
// exchange through an internal temp. All outputs come straight from flops.
module reg_a_writeback
    import reg_a_writeback_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] R11_RST  = '0,
    parameter logic [WIDTH-1:0] R12_RST  = '0,
    parameter logic [WIDTH-1:0] INC_STEP = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             wr_en,
    input  logic             reg_addr,
    input  logic             inc_en,
    input  logic             swap_req,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [WIDTH-1:0] R11,
    output logic [WIDTH-1:0] R12
);

    logic [WIDTH-1:0] r_r11;
    logic [WIDTH-1:0] r_r12;
    logic [WIDTH-1:0] r_tmp;
    logic             r_wrap;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH:0]   w_sum;
    logic             w_idle;
    logic             w_ld_tmp;
    logic             w_ld_r11;
    logic             w_ld_r12;

    reg_a_swap_fsm u_fsm (
        .clk      (clk),
        .rst      (rst),
        .i_start  (swap_req),
        .o_idle   (w_idle),
        .o_busy   (busy),
        .o_done   (done),
        .o_ld_tmp (w_ld_tmp),
        .o_ld_r11 (w_ld_r11),
        .o_ld_r12 (w_ld_r12)
    );

    // Extra MSB of the sum is the overflow carry that drives wrap.
    assign w_sel = (reg_addr == SEL_R12) ? r_r12 : r_r11;
    assign w_sum = {1'b0, w_sel} + {1'b0, INC_STEP};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r11  <= R11_RST;
            r_r12  <= R12_RST;
            r_tmp  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_ld_tmp) r_tmp <= r_r11;
            if (w_ld_r11) r_r11 <= r_r12;
            if (w_ld_r12) r_r12 <= r_tmp;
            // Priority in IDLE: swap > load > increment; losers are dropped.
            if (w_idle && !swap_req) begin
                if (wr_en) begin
                    if (reg_addr == SEL_R12) r_r12 <= bus_in;
                    else                     r_r11 <= bus_in;
                end else if (inc_en) begin
                    if (reg_addr == SEL_R12) r_r12 <= w_sum[WIDTH-1:0];
                    else                     r_r11 <= w_sum[WIDTH-1:0];
                    r_wrap <= w_sum[WIDTH];
                end
            end
        end
    end

    assign wrap = r_wrap;
    assign R11  = r_r11;
    assign R12  = r_r12;

endmodule

// File: tb/tb_reg_a_writeback.sv
// Self-checking bench for reg_a_writeback: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of loads, increments and swaps.
module tb_reg_a_writeback;

    localparam int MASK = (1 << 18) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] bus_in = '0;
    logic        wr_en = 1'b0;
    logic        reg_addr = 1'b0;
    logic        inc_en = 1'b0;
    logic        swap_req = 1'b0;
    logic        busy;
    logic        done;
    logic        wrap;
    logic [17:0] R11;
    logic [17:0] R12;

    int checks = 0;
    int failures = 0;

    // Behavioural model: register values, swap cycles remaining, snapshot at request.
    int m11 = 5, m12 = 9, s11 = 0, s12 = 0, cnt = 0;
    bit mwrap = 0;

    reg_a_writeback #(.WIDTH(18), .R11_RST(18'd5), .R12_RST(18'd9), .INC_STEP(18'd1)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .wr_en(wr_en), .reg_addr(reg_addr),
        .inc_en(inc_en), .swap_req(swap_req), .busy(busy), .done(done), .wrap(wrap),
        .R11(R11), .R12(R12)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit s, input bit w, input bit i, input bit a, input int b);
        swap_req = s; wr_en = w; inc_en = i; reg_addr = a; bus_in = 18'(b);
    endtask

    task automatic cycle();
        int sum;
        @(posedge clk);
        if (rst) begin
            m11 = 5; m12 = 9; cnt = 0; mwrap = 0;
        end else begin
            mwrap = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 1) m11 = s12;
                if (cnt == 0) m12 = s11;
            end else if (swap_req) begin
                cnt = 3; s11 = m11; s12 = m12;
            end else if (wr_en) begin
                if (reg_addr) m12 = int'(bus_in); else m11 = int'(bus_in);
            end else if (inc_en) begin
                sum = (reg_addr ? m12 : m11) + 1;
                mwrap = (sum > MASK);
                if (reg_addr) m12 = sum & MASK; else m11 = sum & MASK;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; drive(0, 0, 0, 0, 0);
        cycle(); cycle();
        rst = 0;
        checks++; if (R11 !== 18'd5) begin failures++; $display("FAIL reset_r11 got=%h exp=5", R11); end
        checks++; if (R12 !== 18'd9) begin failures++; $display("FAIL reset_r12 got=%h exp=9", R12); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    endtask

    task automatic test_load();
        drive(0, 1, 0, 1, 'h12345); cycle();
        checks++; if (R12 !== 18'h12345) begin failures++; $display("FAIL load_r12 got=%h exp=12345", R12); end
        checks++; if (R11 !== 18'd5) begin failures++; $display("FAIL load_r11_hold got=%h exp=5", R11); end
        drive(0, 1, 0, 0, 'h00ABC); cycle();
        checks++; if (R11 !== 18'h00ABC) begin failures++; $display("FAIL load_r11 got=%h exp=00abc", R11); end
        checks++; if (R12 !== 18'h12345) begin failures++; $display("FAIL load_r12_hold got=%h exp=12345", R12); end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_increment_wrap();
        drive(0, 1, 0, 0, 'h3FFFE); cycle();
        drive(0, 0, 1, 0, 0); cycle();
        checks++; if (R11 !== 18'h3FFFF) begin failures++; $display("FAIL inc1_r11 got=%h exp=3ffff", R11); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL inc1_wrap got=%b exp=0", wrap); end
        cycle();
        checks++; if (R11 !== 18'h00000) begin failures++; $display("FAIL inc2_r11 got=%h exp=00000", R11); end
        checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL inc2_wrap got=%b exp=1", wrap); end
        drive(0, 0, 0, 0, 0); cycle();
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL wrap_width got=%b exp=0", wrap); end
        drive(0, 0, 1, 1, 0); cycle();
        checks++; if (R12 !== 18'(m12)) begin failures++; $display("FAIL inc_r12 got=%h exp=%h", R12, m12); end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_swap();
        drive(0, 1, 0, 0, 'h00011); cycle();
        drive(0, 1, 0, 1, 'h00022); cycle();
        drive(1, 0, 0, 0, 0); cycle();
        for (int k = 0; k < 3; k++) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL swap_busy k=%0d got=%b exp=1", k, busy); end
            checks++; if (done !== (k == 2)) begin failures++; $display("FAIL swap_done k=%0d got=%b exp=%b", k, done, k == 2); end
            drive(0, 1, 1, k[0], int'($urandom_range(MASK))); cycle();
        end
        drive(0, 0, 0, 0, 0);
        checks++; if (R11 !== 18'h00022) begin failures++; $display("FAIL swap_r11 got=%h exp=00022", R11); end
        checks++; if (R12 !== 18'h00011) begin failures++; $display("FAIL swap_r12 got=%h exp=00011", R12); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL swap_end busy=%b done=%b exp=0,0", busy, done); end
    endtask

    task automatic test_priority();
        drive(1, 1, 1, 0, 'h3FFFF); cycle();
        drive(0, 0, 0, 0, 0); cycle(); cycle(); cycle();
        checks++; if (R11 !== 18'h00011 || R12 !== 18'h00022) begin failures++; $display("FAIL prio_swap r11=%h r12=%h exp=00011,00022", R11, R12); end
        drive(0, 1, 0, 0, 'h3FFFF); cycle();
        drive(0, 1, 1, 0, 'h00007); cycle();
        checks++; if (R11 !== 18'h00007) begin failures++; $display("FAIL prio_load r11=%h exp=00007", R11); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL prio_wrap got=%b exp=0", wrap); end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_swap();
        drive(1, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0); cycle();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
        rst = 1; cycle(); rst = 0;
        checks++; if (R11 !== 18'd5 || R12 !== 18'd9) begin failures++; $display("FAIL mid_rst_regs r11=%h r12=%h exp=5,9", R11, R12); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_after k=%0d done=%b busy=%b exp=0,0", k, done, busy); end
            cycle();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(63) == 0);
            drive($urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(1) == 0,
                  1'($urandom_range(1)),
                  ($urandom_range(3) == 0) ? MASK - int'($urandom_range(2)) : int'($urandom_range(MASK)));
            cycle();
            checks++;
            if (R11 !== 18'(m11) || R12 !== 18'(m12) || busy !== (cnt != 0) ||
                done !== (cnt == 1) || wrap !== mwrap) begin
                failures++;
                $display("FAIL rand n=%0d got r11=%h r12=%h busy=%b done=%b wrap=%b exp r11=%h r12=%h busy=%b done=%b wrap=%b",
                         n, R11, R12, busy, done, wrap, 18'(m11), 18'(m12), cnt != 0, cnt == 1, mwrap);
            end
        end
        rst = 0; drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_increment_wrap();
        test_swap();
        test_priority();
        test_reset_mid_swap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
